// File: rtl/op_serializer.sv
// op_serializer: captures a WIDTH-bit opcode word and shifts it out MSB-first
// as one start bit plus WIDTH data bits, followed by a forced-low idle gap.
module op_serializer #(
   parameter int WIDTH        = 40,
   parameter int CLKS_PER_BIT = 4,
   parameter int GAP_BITS     = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data,
   input  logic             data_valid,
   output logic             data_ack,
   output logic             sout,
   output logic             busy,
   output logic             frame_done
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;
   localparam int CW = $clog2(WIDTH + GAP_BITS + 1);
   localparam int DW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic [DW-1:0]    div_q, div_d;
   logic             sout_q, sout_d, busy_q, busy_d, ack_q, ack_d, done_q, done_d;
   logic             div_end;

   always_comb begin
      div_end = div_q == DIV_LAST;
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      div_d   = div_end ? '0 : div_q + 1'b1;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (data_valid) begin
               state_d = START;
               shift_d = data;
            end
         end
         START: if (div_end) begin
            state_d = SHIFT;
            bit_d   = CW'(WIDTH - 1);
         end
         SHIFT: if (div_end) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            if (bit_q == '0) begin
               state_d = GAP;
               bit_d   = CW'(GAP_BITS - 1);
            end
         end
         default: if (div_end) begin
            bit_d = bit_q - 1'b1;
            if (bit_q == '0) state_d = IDLE;
         end
      endcase
      // outputs are registered from the upcoming state so they line up with it
      sout_d = state_d == START || (state_d == SHIFT && shift_d[WIDTH-1]);
      busy_d = state_d != IDLE;
      ack_d  = state_q == IDLE && data_valid;
      done_d = state_d == GAP && div_d == DIV_LAST && bit_d == '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign sout       = sout_q;
   assign busy       = busy_q;
   assign data_ack   = ack_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_op_serializer.sv
// tb_op_serializer: random and directed stimulus on two configurations,
// every cycle compared against a frame-position reference model.
module tb_op_serializer;
   localparam int W = 40;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] d1, d2;
   logic         dv1, dv2;
   logic         ack1, sout1, busy1, done1;
   logic         ack2, sout2, busy2, done2;
   logic         mon = 1'b0;
   int           checks = 0, errors = 0;

   always #5 clk = ~clk;

   op_serializer u1 (
      .clk(clk), .reset_n(rst_n), .data(d1), .data_valid(dv1),
      .data_ack(ack1), .sout(sout1), .busy(busy1), .frame_done(done1)
   );

   op_serializer #(.WIDTH(W), .CLKS_PER_BIT(1), .GAP_BITS(1)) u2 (
      .clk(clk), .reset_n(rst_n), .data(d2), .data_valid(dv2),
      .data_ack(ack2), .sout(sout2), .busy(busy2), .frame_done(done2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected {sout,busy,ack,done} given cycles elapsed since capture
   function automatic logic [3:0] expv(input logic act, input int p, input logic [W-1:0] w,
                                       input int cpb, input int gap);
      logic s;
      if (!act) return 4'b0;
      s = p < cpb ? 1'b1 : p < (W + 1) * cpb ? w[W - p / cpb] : 1'b0;
      return {s, 1'b1, p == 0, p == (W + 1 + gap) * cpb - 1};
   endfunction

   logic         a1 = 1'b0, a2 = 1'b0;
   int           p1 = 0, p2 = 0;
   logic [W-1:0] w1 = '0, w2 = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1 <= 1'b0;
         a2 <= 1'b0;
      end else begin
         if (a1) begin
            if (p1 == (W + 1 + 2) * 4 - 1) a1 <= 1'b0;
            p1 <= p1 + 1;
         end else if (dv1) begin
            a1 <= 1'b1; p1 <= 0; w1 <= d1;
         end
         if (a2) begin
            if (p2 == W + 1) a2 <= 1'b0;
            p2 <= p2 + 1;
         end else if (dv2) begin
            a2 <= 1'b1; p2 <= 0; w2 <= d2;
         end
      end
   end

   always @(negedge clk) if (mon) begin
      check("u1_cycle", {sout1, busy1, ack1, done1}, expv(a1, p1, w1, 4, 2));
      check("u2_cycle", {sout2, busy2, ack2, done2}, expv(a2, p2, w2, 1, 1));
   end

   initial begin
      int nbusy, done_at, nack, act, t1, t2;
      logic [41:0] seq, ref_seq;
      rst_n = 1'b0; dv1 = 1'b0; dv2 = 1'b0; d1 = '0; d2 = '0;
      repeat (3) @(negedge clk);
      mon = 1'b1;
      rst_n = 1'b1;
      act = 0;
      repeat (50) begin
         @(negedge clk);
         act += int'(sout1) + int'(busy1) + int'(ack1) + int'(done1);
      end
      check("idle_quiet", act, 0);

      d1 = 40'hc671000000; dv1 = 1'b1;
      nbusy = 0; done_at = 0; nack = 0;
      repeat (200) begin
         @(negedge clk);
         dv1 = 1'b0;
         d1 = {8'($urandom), $urandom};
         if (busy1) nbusy++;
         if (done1) done_at = nbusy;
         if (ack1) nack++;
      end
      check("busy_len", nbusy, 172);
      check("done_at", done_at, 172);
      check("single_ack", nack, 1);

      d1 = 40'h0700000000; dv1 = 1'b1;
      nack = 0; t1 = -1; t2 = -1;
      for (int c = 0; c < 400 && nack < 2; c++) begin
         @(negedge clk);
         if (ack1) begin
            nack++;
            if (nack == 1) t1 = c; else t2 = c;
         end
      end
      dv1 = 1'b0;
      check("b2b_acks", nack, 2);
      check("b2b_period", t2 - t1, 173);
      repeat (180) @(negedge clk);

      d1 = {8'($urandom), $urandom}; dv1 = 1'b1;
      nack = 0;
      for (int c = 0; c < 180; c++) begin
         @(negedge clk);
         if (ack1) nack++;
         dv1 = c < 160 ? 1'($urandom) : 1'b0;
         d1 = {8'($urandom), $urandom};
      end
      check("midframe_ack", nack, 1);

      repeat (1500) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) dv1 = ~dv1;
         if ($urandom_range(0, 3) == 0) d1 = {8'($urandom), $urandom};
      end
      dv1 = 1'b0;
      for (int c = 0; c < 400 && busy1; c++) @(negedge clk);
      check("drain", busy1, 0);

      d1 = {8'($urandom), $urandom} | (40'd1 << 20); dv1 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      for (int c = 0; c < 400 && !(a1 && p1 == 82); c++) @(negedge clk);
      check("bit20_sout", {busy1, sout1}, 2'b11);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {sout1, busy1, ack1, done1}, 4'b0);
      @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (30) begin
         @(negedge clk);
         act += int'(sout1) + int'(busy1) + int'(ack1) + int'(done1);
      end
      check("post_rst_idle", act, 0);

      d2 = 40'h8000000001; dv2 = 1'b1;
      seq = '0; done_at = 0; nack = 0;
      ref_seq = {1'b1, 40'h8000000001, 1'b0};
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         dv2 = 1'b0;
         if (c < 42) seq = {seq[40:0], sout2};
         if (done2) done_at = c + 1;
         if (ack2) nack++;
      end
      check("c1_seq", seq, ref_seq);
      check("c1_done", done_at, 42);
      check("c1_ack", nack, 1);

      repeat (400) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) dv2 = ~dv2;
         if ($urandom_range(0, 2) == 0) d2 = {8'($urandom), $urandom};
      end
      dv2 = 1'b0;
      repeat (50) @(negedge clk);
      mon = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
